// File: rtl/x1_bus_pkg.sv
// rtl/x1_bus_pkg.sv - shared encodings and constants for the X1 bus arbiter
package x1_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VID_RD,
    ST_VID_DATA,
    ST_CPU_RD,
    ST_CPU_DATA,
    ST_CPU_WR
  } state_t;

  localparam logic [7:0]  IPL_ON_PORT     = 8'h1D;
  localparam logic [7:0]  IPL_OFF_PORT    = 8'h1E;
  localparam logic [15:0] IPL_TOP_DEFAULT = 16'h7FFF;

endpackage

// File: rtl/x1_cpu_cycle_det.sv
// rtl/x1_cpu_cycle_det.sv - rising-edge detectors for Z80 memory and I/O-write cycle starts
module x1_cpu_cycle_det (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic cpu_mreq,
  input  logic cpu_iorq,
  input  logic cpu_rd,
  input  logic cpu_wr,
  input  logic cpu_rfsh,
  output logic mem_start,
  output logic io_wr_start
);

  logic mem_act;
  logic io_act;
  logic mem_q;
  logic io_q;

  // Refresh cycles also raise mreq; they must never reach the RAM.
  assign mem_act = cpu_mreq & (cpu_rd | cpu_wr) & ~cpu_rfsh;
  assign io_act  = cpu_iorq & cpu_wr;

  assign mem_start   = mem_act & ~mem_q;
  assign io_wr_start = io_act & ~io_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= 1'b0;
      io_q  <= 1'b0;
    end else begin
      mem_q <= mem_act;
      io_q  <= io_act;
    end
  end

endmodule

// File: rtl/x1_bus_arbiter.sv
// rtl/x1_bus_arbiter.sv - single-port main RAM sharing between Z80 and video fetch, plus IPL ROM overlay
module x1_bus_arbiter
  import x1_bus_pkg::*;
#(
  parameter int          AW      = 16,
  parameter int          ROM_AW  = 12,
  parameter logic [15:0] IPL_TOP = IPL_TOP_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              cpu_mreq,
  input  logic              cpu_iorq,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic              cpu_rfsh,
  input  logic [15:0]       cpu_a,
  input  logic [7:0]        cpu_dout,
  output logic [7:0]        cpu_din,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [AW-1:0]     vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_dout,
  output logic              ipl_en
);

  state_t        state;
  logic          mem_start;
  logic          io_wr_start;
  logic          cpu_pend;
  logic          cpu_we_q;
  logic          cpu_rom_q;
  logic [15:0]   cpu_addr_q;
  logic [7:0]    cpu_data_q;
  logic          vid_pend;
  logic [AW-1:0] vid_addr_q;
  logic          last_vid;
  logic          wait_q;

  x1_cpu_cycle_det u_cycle_det (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .cpu_mreq    (cpu_mreq),
    .cpu_iorq    (cpu_iorq),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_rfsh    (cpu_rfsh),
    .mem_start   (mem_start),
    .io_wr_start (io_wr_start)
  );

  // Wait must drop in the very cycle the access starts, before the register catches up.
  assign cpu_wait_n = wait_q & ~mem_start;
  assign rom_addr   = cpu_a[ROM_AW-1:0];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cpu_din    <= 8'h00;
      wait_q     <= 1'b1;
      vid_ack    <= 1'b0;
      vid_data   <= 8'h00;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_din    <= 8'h00;
      ipl_en     <= 1'b1;
      cpu_pend   <= 1'b0;
      cpu_we_q   <= 1'b0;
      cpu_rom_q  <= 1'b0;
      cpu_addr_q <= 16'h0000;
      cpu_data_q <= 8'h00;
      vid_pend   <= 1'b0;
      vid_addr_q <= '0;
      last_vid   <= 1'b0;
    end else begin
      vid_ack <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Video normally wins; right after a video grant a waiting CPU goes first.
          if (vid_pend && !(cpu_pend && last_vid)) begin
            state    <= ST_VID_RD;
            ram_addr <= vid_addr_q;
            vid_pend <= 1'b0;
            last_vid <= 1'b1;
          end else if (cpu_pend) begin
            cpu_pend <= 1'b0;
            last_vid <= 1'b0;
            ram_addr <= cpu_addr_q[AW-1:0];
            if (cpu_we_q) begin
              ram_we  <= 1'b1;
              ram_din <= cpu_data_q;
              state   <= ST_CPU_WR;
            end else begin
              state   <= ST_CPU_RD;
            end
          end
        end
        ST_VID_RD:   state <= ST_VID_DATA;
        ST_VID_DATA: begin
          vid_data <= ram_dout;
          vid_ack  <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_CPU_RD:   state <= ST_CPU_DATA;
        ST_CPU_DATA: begin
          cpu_din <= cpu_rom_q ? rom_dout : ram_dout;
          wait_q  <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_CPU_WR: begin
          ram_we <= 1'b0;
          wait_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default:     state <= ST_IDLE;
      endcase

      // Captures follow the grant logic so a request on the grant edge is kept.
      if (mem_start) begin
        cpu_pend   <= 1'b1;
        cpu_addr_q <= cpu_a;
        cpu_data_q <= cpu_dout;
        cpu_we_q   <= cpu_wr;
        cpu_rom_q  <= ipl_en && (cpu_a <= IPL_TOP);
        wait_q     <= 1'b0;
      end

      if (vid_req) begin
        vid_pend   <= 1'b1;
        vid_addr_q <= vid_addr;
      end

      if (io_wr_start) begin
        if (cpu_a[15:8] == IPL_OFF_PORT) begin
          ipl_en <= 1'b0;
        end else if (cpu_a[15:8] == IPL_ON_PORT) begin
          ipl_en <= 1'b1;
        end
      end
    end
  end

endmodule
